// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared tags, grant states and size codes
package mem_port_arbiter_pkg;
    localparam logic TAG_INST = 1'b0;
    localparam logic TAG_DATA = 1'b1;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    typedef enum logic [1:0] {FREE, HOLD_I, HOLD_D} grant_state_e;
endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// tag_fifo: small in-order FIFO of response routing tags
module tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    // pointers wrap modulo DEPTH; a simultaneous push and pop keeps the count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    // tag storage needs no reset, only slots below count are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges inst and data ports onto one in-order memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_unexp
);
    grant_state_e state, state_nxt;
    logic grant_d, gr_req, full, empty, head, push, pop;
    assign grant_d      = (state == HOLD_D) || (state == FREE && data_req);
    assign gr_req       = grant_d ? data_req : inst_req;
    assign mem_req      = resetn && gr_req && !full;
    assign push         = mem_req && mem_addr_ok;
    assign pop          = resetn && mem_data_ok && !empty;
    assign inst_addr_ok = push && !grant_d;
    assign data_addr_ok = push && grant_d;
    assign inst_data_ok = pop && head == TAG_INST;
    assign data_data_ok = pop && head == TAG_DATA;
    assign mem_wr       = resetn && grant_d && data_wr;
    assign mem_size     = !resetn ? '0 : grant_d ? data_size : SIZE_WORD;
    assign mem_wstrb    = (resetn && grant_d) ? data_wstrb : '0;
    assign mem_addr     = !resetn ? '0 : grant_d ? data_addr : inst_addr;
    assign mem_wdata    = (resetn && grant_d) ? data_wdata : '0;
    assign inst_rdata   = resetn ? mem_rdata : '0;
    assign data_rdata   = resetn ? mem_rdata : '0;
    tag_fifo #(.DEPTH(MAX_OUT), .WIDTH(1)) u_tags (
        .clk   (clk),
        .resetn(resetn),
        .push  (push),
        .pop   (pop),
        .din   (grant_d),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
    // grant state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= FREE;
        else state <= state_nxt;
    end
    // lock onto a stalled master until its handshake, release if it drops its request
    always_comb begin
        state_nxt = state;
        state_nxt = (state == FREE) ? ((mem_req && !mem_addr_ok) ? (grant_d ? HOLD_D : HOLD_I) : FREE)
                                    : ((!gr_req || push) ? FREE : state);
    end
    // a response with nothing outstanding is flagged until reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_unexp <= 1'b0;
        else if (mem_data_ok && empty) err_unexp <= 1'b1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a queue model
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic inst_req, inst_addr_ok, inst_data_ok;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata, data_rdata, mem_rdata, data_wdata, mem_wdata;
    logic data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0] data_size, mem_size;
    logic [3:0] data_wstrb, mem_wstrb;
    logic [AW-1:0] data_addr, mem_addr;
    logic mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_unexp;
    logic [140:0] all_out;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign all_out = {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata, inst_addr_ok, inst_data_ok,
                      data_addr_ok, data_data_ok, inst_rdata, data_rdata, err_unexp};

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_unexp(err_unexp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        inst_req = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    endtask

    task automatic test_reset;
        resetn = 0;
        inst_req = 1; data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_size = 2;
        data_addr = 32'h8000_0000; data_wdata = 32'hA5A5_A5A5; inst_addr = 32'hBFC0_0000;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        #3;
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
        tick;
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL reset_outputs_edge got=%h exp=0", all_out); end
        idle;
        @(negedge clk);
        resetn = 1;
        tick;
        checks++;
        if ({err_unexp, mem_req} !== 2'b00) begin failures++; $display("FAIL reset_release got=%b exp=00", {err_unexp, mem_req}); end
    endtask

    task automatic test_single_inst;
        logic [DW-1:0] rd;
        inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
        #4;
        checks++;
        if ({mem_req, inst_addr_ok, data_addr_ok, mem_wr, mem_size} !== 6'b110010) begin
            failures++; $display("FAIL single_accept got=%b exp=110010", {mem_req, inst_addr_ok, data_addr_ok, mem_wr, mem_size});
        end
        checks++;
        if (mem_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL single_addr got=%h exp=bfc00000", mem_addr); end
        tick;
        inst_req = 0; mem_addr_ok = 0;
        for (int c = 1; c < 3; c++) begin
            #4;
            checks++;
            if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL single_early_resp got=%b exp=00", {inst_data_ok, data_data_ok}); end
            tick;
        end
        rd = $urandom; mem_rdata = rd; mem_data_ok = 1;
        #4;
        checks++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, rd}) begin
            failures++; $display("FAIL single_resp got=%b/%h exp=10/%h", {inst_data_ok, data_data_ok}, inst_rdata, rd);
        end
        tick;
        mem_data_ok = 0;
    endtask

    task automatic test_simultaneous;
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hF; data_addr = 32'h8000_1000; data_wdata = 32'h1234_5678;
        mem_addr_ok = 1;
        #4;
        checks++;
        if ({data_addr_ok, inst_addr_ok, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== {3'b101, 4'hF, 32'h8000_1000, 32'h1234_5678}) begin
            failures++; $display("FAIL simul_data_first got=%b%b%b %h %h %h exp=101 f 80001000 12345678",
                                 data_addr_ok, inst_addr_ok, mem_wr, mem_wstrb, mem_addr, mem_wdata);
        end
        tick;
        data_req = 0; data_wr = 0;
        #4;
        checks++;
        if ({inst_addr_ok, data_addr_ok, mem_wr, mem_wstrb, mem_wdata, mem_addr} !== {3'b100, 4'h0, 32'h0, 32'hBFC0_0004}) begin
            failures++; $display("FAIL simul_inst_next got=%b%b%b %h %h %h exp=100 0 0 bfc00004",
                                 inst_addr_ok, data_addr_ok, mem_wr, mem_wstrb, mem_wdata, mem_addr);
        end
        tick;
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #4;
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b10) begin failures++; $display("FAIL simul_resp_d got=%b exp=10", {data_data_ok, inst_data_ok}); end
        tick;
        #4;
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b01) begin failures++; $display("FAIL simul_resp_i got=%b exp=01", {data_data_ok, inst_data_ok}); end
        tick;
        mem_data_ok = 0;
    endtask

    task automatic test_hold;
        inst_req = 1; inst_addr = 32'hBFC0_0008; mem_addr_ok = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin data_req = 1; data_wr = 0; data_size = 0; data_addr = 32'h8000_2000; end
            #4;
            checks++;
            if ({mem_req, inst_addr_ok, data_addr_ok, mem_addr} !== {3'b100, 32'hBFC0_0008}) begin
                failures++; $display("FAIL hold_cycle%0d got=%b %h exp=100 bfc00008", c, {mem_req, inst_addr_ok, data_addr_ok}, mem_addr);
            end
            tick;
        end
        mem_addr_ok = 1;
        #4;
        checks++;
        if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b10, 32'hBFC0_0008}) begin
            failures++; $display("FAIL hold_release got=%b %h exp=10 bfc00008", {inst_addr_ok, data_addr_ok}, mem_addr);
        end
        tick;
        inst_req = 0;
        #4;
        checks++;
        if ({inst_addr_ok, data_addr_ok, mem_size, mem_addr} !== {2'b01, 2'd0, 32'h8000_2000}) begin
            failures++; $display("FAIL hold_data_after got=%b %h exp=0100 80002000", {inst_addr_ok, data_addr_ok, mem_size}, mem_addr);
        end
        tick;
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #4;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL hold_resp_i got=%b exp=10", {inst_data_ok, data_data_ok}); end
        tick;
        #4;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL hold_resp_d got=%b exp=01", {inst_data_ok, data_data_ok}); end
        tick;
        mem_data_ok = 0;
    endtask

    task automatic test_full;
        inst_req = 1; inst_addr = 32'hBFC0_0010; mem_addr_ok = 1;
        for (int c = 0; c < 2; c++) begin
            #4;
            checks++;
            if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL full_fill%0d got=%b exp=1", c, inst_addr_ok); end
            tick;
        end
        #4;
        checks++;
        if ({mem_req, inst_addr_ok} !== 2'b00) begin failures++; $display("FAIL full_block got=%b exp=00", {mem_req, inst_addr_ok}); end
        tick;
        mem_data_ok = 1;
        #4;
        checks++;
        if ({mem_req, inst_data_ok} !== 2'b01) begin failures++; $display("FAIL full_pop_no_push got=%b exp=01", {mem_req, inst_data_ok}); end
        tick;
        mem_data_ok = 0;
        #4;
        checks++;
        if ({mem_req, inst_addr_ok} !== 2'b11) begin failures++; $display("FAIL full_freed got=%b exp=11", {mem_req, inst_addr_ok}); end
        tick;
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        for (int c = 0; c < 2; c++) begin
            #4;
            checks++;
            if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL full_drain%0d got=%b exp=10", c, {inst_data_ok, data_data_ok}); end
            tick;
        end
        mem_data_ok = 0;
        #4;
        checks++;
        if (err_unexp !== 1'b0) begin failures++; $display("FAIL full_no_err got=%b exp=0", err_unexp); end
        tick;
    endtask

    task automatic test_unexpected;
        mem_data_ok = 1;
        #4;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL unexp_no_ok got=%b exp=00", {inst_data_ok, data_data_ok}); end
        tick;
        mem_data_ok = 0;
        #4;
        checks++;
        if (err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_set got=%b exp=1", err_unexp); end
        tick;
        tick;
        checks++;
        if (err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_sticky got=%b exp=1", err_unexp); end
        data_req = 1; data_addr = 32'h8000_3000; mem_addr_ok = 1;
        tick;
        data_req = 0; inst_req = 1; inst_addr = 32'hBFC0_0020; mem_data_ok = 0;
        #2;
        resetn = 0;
        #1;
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL async_reset got=%h exp=0", all_out); end
        @(negedge clk);
        idle;
        resetn = 1;
        tick;
        inst_req = 1; inst_addr = 32'hBFC0_0020; mem_addr_ok = 1;
        #4;
        checks++;
        if ({err_unexp, inst_addr_ok} !== 2'b01) begin failures++; $display("FAIL post_reset_accept got=%b exp=01", {err_unexp, inst_addr_ok}); end
        tick;
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #4;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL post_reset_fifo got=%b exp=10", {inst_data_ok, data_data_ok}); end
        tick;
        mem_data_ok = 0;
    endtask

    task automatic test_random;
        bit q[$];
        int locked = -1;
        int owner;
        bit oreq, e_req, e_acc, e_pop, e_tag;
        logic [70:0] e_fields;
        for (int n = 0; n < 400; n++) begin
            if (!inst_req) begin inst_req = 1'($urandom_range(0, 1)); inst_addr = $urandom; end
            if (!data_req) begin
                data_req = 1'($urandom_range(0, 1)); data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2)); data_wstrb = 4'($urandom);
                data_addr = $urandom; data_wdata = $urandom;
            end
            mem_addr_ok = $urandom_range(0, 2) != 0;
            mem_data_ok = q.size() > 0 && $urandom_range(0, 1) == 1;
            mem_rdata = $urandom;
            owner = locked >= 0 ? locked : int'(data_req);
            oreq = owner == 1 ? data_req : inst_req;
            e_req = oreq && q.size() < MO;
            e_acc = e_req && mem_addr_ok;
            e_pop = mem_data_ok && q.size() > 0;
            e_tag = e_pop ? q[0] : 1'b0;
            e_fields = owner == 1 ? {data_addr, data_wr, data_size, data_wstrb, data_wdata}
                                  : {inst_addr, 1'b0, 2'd2, 4'h0, 32'h0};
            #4;
            checks++;
            if ({mem_req, inst_addr_ok, data_addr_ok} !== {e_req, e_acc && owner == 0, e_acc && owner == 1}) begin
                failures++; $display("FAIL rand_req n=%0d got=%b exp=%b", n, {mem_req, inst_addr_ok, data_addr_ok},
                                     {e_req, e_acc && owner == 0, e_acc && owner == 1});
            end
            checks++;
            if ({inst_data_ok, data_data_ok} !== {e_pop && !e_tag, e_pop && e_tag}) begin
                failures++; $display("FAIL rand_resp n=%0d got=%b exp=%b", n, {inst_data_ok, data_data_ok}, {e_pop && !e_tag, e_pop && e_tag});
            end
            checks++;
            if ({mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata} !== e_fields) begin
                failures++; $display("FAIL rand_fields n=%0d got=%h exp=%h", n, {mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata}, e_fields);
            end
            checks++;
            if ({inst_rdata, data_rdata} !== {mem_rdata, mem_rdata}) begin
                failures++; $display("FAIL rand_rdata n=%0d got=%h/%h exp=%h", n, inst_rdata, data_rdata, mem_rdata);
            end
            if (e_pop) void'(q.pop_front());
            if (e_acc) q.push_back(owner == 1);
            if (locked < 0) begin
                if (e_req && !mem_addr_ok) locked = owner;
            end else if (!oreq || e_acc) locked = -1;
            tick;
            if (e_acc && owner == 1) data_req = 0;
            if (e_acc && owner == 0) inst_req = 0;
        end
        checks++;
        if (err_unexp !== 1'b0) begin failures++; $display("FAIL rand_err got=%b exp=0", err_unexp); end
        idle;
    endtask

    initial begin
        idle;
        test_reset;
        test_single_inst;
        test_simultaneous;
        test_hold;
        test_full;
        test_unexpected;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
